// File: rtl/mdu_pkg.sv
// Shared MDU constants: op codes, default latencies, control FSM states.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6
    } mdu_op_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } mdu_state_e;

    // mult/multu/div/divu occupy the unit for several cycles; everything else does not.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// MDU sequencing: issue acceptance, busy flag and latency counter.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start_i     - issue strobe
//   op_i        - MDU op code (valid with start_i)
//   accept_o    - issue accepted this cycle (any op code)
//   commit_o    - one-cycle pulse: datapath writes HI/LO at this edge
//   busy_o      - long operation in flight
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [3:0] op_i,
    output logic       accept_o,
    output logic       commit_o,
    output logic       busy_o
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    mdu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_o = start_i && (state_q == ST_IDLE) && !reset;
        commit_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_o && is_long_op(op_i)) begin
                    if ((op_i == MDU_MULT) || (op_i == MDU_MULTU)) begin
                        cnt_d = CW'(MULT_CYCLES);
                    end else begin
                        cnt_d = CW'(DIV_CYCLES);
                    end
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                // The edge taking the counter 1->0 is the write edge.
                if (cnt_q == CW'(1)) begin
                    commit_o = !reset;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q == ST_BUSY);

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   A, B       - rs / rt operands, latched at issue
//   MDUOp      - op code (none/mult/multu/div/divu/mthi/mtlo), valid with start
//   start      - issue strobe
//   busy       - long operation in flight
//   HI, LO     - architectural HI/LO registers
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic        accept, commit;
    logic [63:0] res_q, res_d;
    logic        skip_q, skip_d;
    logic [31:0] hi_q, lo_q;

    logic [63:0] mul_a, mul_b, prod;
    logic        sdiv, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    mdu_ctrl #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .op_i    (MDUOp),
        .accept_o(accept),
        .commit_o(commit),
        .busy_o  (busy)
    );

    // Result is computed from the issue-cycle operands and parked in res_q,
    // so later A/B changes cannot affect it.
    always_comb begin
        mul_a = (MDUOp == MDU_MULT) ? {{32{A[31]}}, A} : {32'b0, A};
        mul_b = (MDUOp == MDU_MULT) ? {{32{B[31]}}, B} : {32'b0, B};
        prod  = mul_a * mul_b;

        // Signed divide via magnitudes: avoids the INT_MIN / -1 overflow case
        // (magnitude 0x80000000 / 1 yields the required 0x80000000, rem 0).
        sdiv   = (MDUOp == MDU_DIV);
        a_neg  = sdiv && A[31];
        b_neg  = sdiv && B[31];
        a_mag  = a_neg ? -A : A;
        b_mag  = b_neg ? -B : B;
        b_safe = (B == '0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;

        res_d  = res_q;
        skip_d = skip_q;
        if (accept && is_long_op(MDUOp)) begin
            if ((MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU)) begin
                res_d  = prod;
                skip_d = 1'b0;
            end else begin
                res_d  = {rem, quot};
                skip_d = (B == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q  <= '0;
            skip_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            res_q  <= res_d;
            skip_q <= skip_d;
            if (commit && !skip_q) begin
                hi_q <= res_q[63:32];
                lo_q <= res_q[31:0];
            end
            if (accept && (MDUOp == MDU_MTHI)) begin
                hi_q <= A;
            end
            if (accept && (MDUOp == MDU_MTLO)) begin
                lo_q <= A;
            end
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule
